// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_ctrl
// Purpose  : Queues branch-resolution updates from EXE and turns each one into
//            a single BTB write (allocate / strengthen / weaken / invalidate).
//            Also sequences a full-table invalidation on request.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
  parameter int BLOCKSIZE = 4,
  parameter int QDEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_valid,
  input  logic [31:0]                   upd_pc,
  input  logic [31:0]                   upd_target,
  input  logic                          upd_taken,
  output logic                          upd_ready,
  input  logic                          flush_req,
  output logic                          flush_busy,
  output logic                          btb_we,
  output logic [$clog2(BLOCKSIZE)-1:0]  btb_idx,
  output logic [31:0]                   btb_wpc,
  output logic [31:0]                   btb_waddr,
  output logic                          btb_wvalid,
  output logic [BLOCKSIZE-1:0]          entry_valid
);

  localparam int IW = $clog2(BLOCKSIZE);
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;

  // Update queue storage
  logic [31:0]       q_pc  [QDEPTH];
  logic [31:0]       q_tgt [QDEPTH];
  logic [QDEPTH-1:0] q_tk;
  logic [QW-1:0]     wr_ptr;
  logic [QW-1:0]     rd_ptr;
  logic [QW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              start_flush;

  // Shadow copy of the BTB bookkeeping
  logic [BLOCKSIZE-1:0] valid;
  logic [31:0]          tag [BLOCKSIZE];
  logic [1:0]           ctr [BLOCKSIZE];
  logic [IW-1:0]        rr_ptr;

  // Lookup results for the queue head
  logic [31:0]   head_pc;
  logic [31:0]   head_tgt;
  logic          head_tk;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          has_free;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] alloc_idx;

  assign full        = (count == (QW+1)'(QDEPTH));
  assign empty       = (count == '0);
  assign upd_ready   = !rst && !full && !flush_req && (state != FLUSH);
  assign push        = upd_valid && upd_ready;
  // A flush request is honoured from IDLE or at the end of a WRITE cycle
  assign start_flush = flush_req && ((state == IDLE) || (state == WRITE));
  assign pop         = (state == IDLE) && !flush_req && !empty;
  assign entry_valid = valid;

  assign head_pc  = q_pc[rd_ptr];
  assign head_tgt = q_tgt[rd_ptr];
  assign head_tk  = q_tk[rd_ptr];

  // Tag match and lowest-free search; descending scan leaves the lowest index
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = BLOCKSIZE - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == head_pc)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    alloc_idx = has_free ? free_idx : rr_ptr;
  end

  // Update FIFO; entering FLUSH discards everything still pending
  always_ff @(posedge clk) begin
    if (rst || start_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]  <= upd_pc;
        q_tgt[wr_ptr] <= upd_target;
        q_tk[wr_ptr]  <= upd_taken;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control FSM with registered BTB write port and shadow-state maintenance
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      btb_we     <= 1'b0;
      btb_idx    <= '0;
      btb_wpc    <= '0;
      btb_waddr  <= '0;
      btb_wvalid <= 1'b0;
      flush_busy <= 1'b0;
      valid      <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < BLOCKSIZE; i++) begin
        tag[i] <= '0;
        ctr[i] <= 2'b00;
      end
    end else if (start_flush) begin
      // First flush cycle: invalidate entry 0 on the way in
      state      <= FLUSH;
      flush_busy <= 1'b1;
      btb_we     <= 1'b1;
      btb_idx    <= '0;
      btb_wpc    <= '0;
      btb_waddr  <= '0;
      btb_wvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          btb_we <= 1'b0;
          if (pop) begin
            if (hit) begin
              state     <= WRITE;
              btb_we    <= 1'b1;
              btb_idx   <= hit_idx;
              btb_wpc   <= head_pc;
              btb_waddr <= head_tgt;
              if (head_tk) begin
                btb_wvalid <= 1'b1;
                if (ctr[hit_idx] != 2'b11) ctr[hit_idx] <= ctr[hit_idx] + 2'd1;
              end else if (ctr[hit_idx] <= 2'b01) begin
                // Weakened to 00: the entry no longer predicts anything
                btb_wvalid     <= 1'b0;
                valid[hit_idx] <= 1'b0;
                ctr[hit_idx]   <= 2'b00;
              end else begin
                btb_wvalid   <= 1'b1;
                ctr[hit_idx] <= ctr[hit_idx] - 2'd1;
              end
            end else if (head_tk) begin
              state            <= WRITE;
              btb_we           <= 1'b1;
              btb_idx          <= alloc_idx;
              btb_wpc          <= head_pc;
              btb_waddr        <= head_tgt;
              btb_wvalid       <= 1'b1;
              valid[alloc_idx] <= 1'b1;
              tag[alloc_idx]   <= head_pc;
              ctr[alloc_idx]   <= 2'b10;
              if (!has_free) rr_ptr <= rr_ptr + 1'b1;
            end
            // Miss and not taken: the update is simply dropped
          end
        end
        WRITE: begin
          btb_we <= 1'b0;
          state  <= IDLE;
        end
        FLUSH: begin
          // A repeated flush_req here is ignored; the walk just continues
          if (btb_idx == IW'(BLOCKSIZE - 1)) begin
            state      <= IDLE;
            btb_we     <= 1'b0;
            flush_busy <= 1'b0;
            valid      <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < BLOCKSIZE; i++) begin
              ctr[i] <= 2'b00;
            end
          end else begin
            btb_idx <= btb_idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          btb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_ctrl
// Purpose  : Directed self-checking bench for btb_update_ctrl (4 entries,
//            2-deep queue) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_ready;
  logic        flush_req;
  logic        flush_busy;
  logic        btb_we;
  logic [1:0]  btb_idx;
  logic [31:0] btb_wpc;
  logic [31:0] btb_waddr;
  logic        btb_wvalid;
  logic [3:0]  entry_valid;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] stream [4];
  logic [31:0] wr_seen [8];
  int          idx_in;
  int          nwr;
  logic        fire;

  btb_update_ctrl #(
    .BLOCKSIZE (4),
    .QDEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .upd_ready   (upd_ready),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .btb_we      (btb_we),
    .btb_idx     (btb_idx),
    .btb_wpc     (btb_wpc),
    .btb_waddr   (btb_waddr),
    .btb_wvalid  (btb_wvalid),
    .entry_valid (entry_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    upd_valid = 1'b0;
    flush_req = 1'b0;
    tick();
    tick();
    check_val("rst_we",     32'(btb_we),      32'd0);
    check_val("rst_idx",    32'(btb_idx),     32'd0);
    check_val("rst_wpc",    btb_wpc,          32'd0);
    check_val("rst_waddr",  btb_waddr,        32'd0);
    check_val("rst_wvalid", 32'(btb_wvalid),  32'd0);
    check_val("rst_busy",   32'(flush_busy),  32'd0);
    check_val("rst_ready",  32'(upd_ready),   32'd0);
    check_val("rst_valid",  32'(entry_valid), 32'd0);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", 32'(upd_ready), 32'd1);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
    check_val("push_ready", 32'(upd_ready), 32'd1);
    tick();
    upd_valid = 1'b0;
  endtask

  // Called right after push1: write is visible one cycle later, for one cycle
  task automatic expect_write(input string tag, input logic [31:0] idx,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input logic wv);
    tick();
    check_val({tag, "_we"},     32'(btb_we),     32'd1);
    check_val({tag, "_idx"},    32'(btb_idx),    idx);
    check_val({tag, "_wpc"},    btb_wpc,         pc);
    check_val({tag, "_waddr"},  btb_waddr,       tgt);
    check_val({tag, "_wvalid"}, 32'(btb_wvalid), 32'(wv));
    tick();
    check_val({tag, "_we_off"}, 32'(btb_we),     32'd0);
  endtask

  task automatic expect_nowrite(input string tag);
    tick();
    check_val({tag, "_we0"}, 32'(btb_we), 32'd0);
    tick();
    check_val({tag, "_we1"}, 32'(btb_we), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_target = '0;
    upd_taken  = 1'b0;
    flush_req  = 1'b0;

    // ---- single allocation, exact latency ----
    do_reset();
    push1(32'h100, 32'h140, 1'b1);
    check_val("lat_we_early", 32'(btb_we), 32'd0);
    expect_write("alloc0", 32'd0, 32'h100, 32'h140, 1'b1);
    check_val("alloc0_ev", 32'(entry_valid), 32'h1);

    // ---- fill table, then round-robin replacement and hits ----
    do_reset();
    push1(32'h100, 32'h1100, 1'b1); expect_write("rr_a", 32'd0, 32'h100, 32'h1100, 1'b1);
    push1(32'h200, 32'h1200, 1'b1); expect_write("rr_b", 32'd1, 32'h200, 32'h1200, 1'b1);
    push1(32'h300, 32'h1300, 1'b1); expect_write("rr_c", 32'd2, 32'h300, 32'h1300, 1'b1);
    push1(32'h400, 32'h1400, 1'b1); expect_write("rr_d", 32'd3, 32'h400, 32'h1400, 1'b1);
    check_val("rr_full_ev", 32'(entry_valid), 32'hF);
    push1(32'h500, 32'h1500, 1'b1); expect_write("rr_e", 32'd0, 32'h500, 32'h1500, 1'b1);
    push1(32'h300, 32'h1300, 1'b1); expect_write("hit_c", 32'd2, 32'h300, 32'h1300, 1'b1);
    push1(32'h600, 32'h1600, 1'b1); expect_write("rr_f", 32'd1, 32'h600, 32'h1600, 1'b1);

    // ---- counter walk down, drop, saturation ----
    do_reset();
    push1(32'h100, 32'h180, 1'b1); expect_write("dec_alloc", 32'd0, 32'h100, 32'h180, 1'b1);
    push1(32'h100, 32'h180, 1'b0); expect_write("dec_01",    32'd0, 32'h100, 32'h180, 1'b1);
    push1(32'h100, 32'h180, 1'b0); expect_write("dec_00",    32'd0, 32'h100, 32'h180, 1'b0);
    check_val("dec_ev", 32'(entry_valid), 32'h0);
    push1(32'h900, 32'h980, 1'b0); expect_nowrite("drop");
    check_val("drop_hold_wpc",    btb_wpc,         32'h100);
    check_val("drop_hold_wvalid", 32'(btb_wvalid), 32'd0);
    push1(32'h200, 32'h280, 1'b1); expect_write("sat_alloc", 32'd0, 32'h200, 32'h280, 1'b1);
    push1(32'h200, 32'h280, 1'b1); expect_write("sat_11",    32'd0, 32'h200, 32'h280, 1'b1);
    push1(32'h200, 32'h280, 1'b1); expect_write("sat_hold",  32'd0, 32'h200, 32'h280, 1'b1);
    push1(32'h200, 32'h280, 1'b0); expect_write("sat_10",    32'd0, 32'h200, 32'h280, 1'b1);
    push1(32'h200, 32'h280, 1'b0); expect_write("sat_01",    32'd0, 32'h200, 32'h280, 1'b1);
    push1(32'h200, 32'h280, 1'b0); expect_write("sat_00",    32'd0, 32'h200, 32'h280, 1'b0);

    // ---- back-to-back stream: backpressure, no loss, no duplication ----
    do_reset();
    stream[0] = 32'h1000; stream[1] = 32'h2000; stream[2] = 32'h3000; stream[3] = 32'h4000;
    idx_in     = 0;
    nwr        = 0;
    upd_valid  = 1'b1;
    upd_pc     = stream[0];
    upd_target = stream[0] + 32'h10;
    upd_taken  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) check_val("q_full_ready", 32'(upd_ready), 32'd0);
      if (c == 4) check_val("q_pop_ready",  32'(upd_ready), 32'd1);
      fire = upd_valid && upd_ready;
      tick();
      if (fire) begin
        idx_in++;
        if (idx_in < 4) begin
          upd_pc     = stream[idx_in];
          upd_target = stream[idx_in] + 32'h10;
        end else begin
          upd_valid = 1'b0;
        end
      end
      if (btb_we) begin
        if (nwr < 8) wr_seen[nwr] = btb_wpc;
        nwr++;
      end
    end
    upd_valid = 1'b0;
    check_val("q_nwr", 32'(nwr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("q_order%0d", i), wr_seen[i], stream[i]);
    end

    // ---- flush during WRITE with pending updates ----
    do_reset();
    upd_valid = 1'b1; upd_taken = 1'b1;
    upd_pc = 32'h100; upd_target = 32'h180;
    tick();
    upd_pc = 32'h200; upd_target = 32'h280;
    tick();
    check_val("fl_wa_wpc", btb_wpc, 32'h100);
    upd_pc = 32'h300; upd_target = 32'h380;
    tick();
    upd_valid = 1'b0;
    check_val("fl_full_ready", 32'(upd_ready), 32'd0);
    tick();
    check_val("fl_wb_we",  32'(btb_we), 32'd1);
    check_val("fl_wb_wpc", btb_wpc,     32'h200);
    check_val("fl_wb_idx", 32'(btb_idx), 32'd1);
    flush_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) flush_req = 1'b0;
      check_val($sformatf("fl_busy%0d", k),   32'(flush_busy), 32'd1);
      check_val($sformatf("fl_we%0d", k),     32'(btb_we),     32'd1);
      check_val($sformatf("fl_idx%0d", k),    32'(btb_idx),    32'(k));
      check_val($sformatf("fl_wvalid%0d", k), 32'(btb_wvalid), 32'd0);
      if (k == 0) begin
        check_val("fl_wpc",   btb_wpc,        32'd0);
        check_val("fl_waddr", btb_waddr,      32'd0);
        check_val("fl_ready", 32'(upd_ready), 32'd0);
      end
    end
    tick();
    check_val("fl_end_busy", 32'(flush_busy),  32'd0);
    check_val("fl_end_we",   32'(btb_we),      32'd0);
    check_val("fl_end_ev",   32'(entry_valid), 32'd0);
    check_val("fl_end_idx",  32'(btb_idx),     32'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("fl_discard%0d", k), 32'(btb_we), 32'd0);
    end

    // ---- reset in the second flush cycle ----
    do_reset();
    push1(32'h100, 32'h140, 1'b1); expect_write("rf_alloc", 32'd0, 32'h100, 32'h140, 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    check_val("rf_idx1", 32'(btb_idx), 32'd1);
    rst = 1'b1;
    tick();
    check_val("rf_we",     32'(btb_we),      32'd0);
    check_val("rf_idx",    32'(btb_idx),     32'd0);
    check_val("rf_wpc",    btb_wpc,          32'd0);
    check_val("rf_waddr",  btb_waddr,        32'd0);
    check_val("rf_wvalid", 32'(btb_wvalid),  32'd0);
    check_val("rf_busy",   32'(flush_busy),  32'd0);
    check_val("rf_ready",  32'(upd_ready),   32'd0);
    check_val("rf_ev",     32'(entry_valid), 32'd0);
    rst = 1'b0;
    tick();
    check_val("rf_after_we",   32'(btb_we),     32'd0);
    check_val("rf_after_busy", 32'(flush_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL provide parameter BLOCKSIZE, default 4, the number of BTB entries (power of 2, >=2); IW = log2(BLOCKSIZE).
REQ-002 SHALL provide parameter QDEPTH, default 2, the depth of the update queue (power of 2).
REQ-003 SHALL use one clock and a synchronous active-high reset: clk and rst.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 upd_valid  in  1  branch-resolution update offered by the EXE stage.
REQ-007 upd_pc  in  32  PC of the resolved branch.
REQ-008 upd_target  in  32  resolved target (pc+imm).
REQ-009 upd_taken  in  1  branch outcome.
REQ-010 upd_ready  out  1  the queue accepts the update this cycle.
REQ-011 flush_req  in  1  request to invalidate every BTB entry.
REQ-012 flush_busy  out  1  flush sequence in progress.
REQ-013 btb_we  out  1  BTB write strobe.
REQ-014 btb_idx  out  IW  BTB entry index written.
REQ-015 btb_wpc  out  32  tag written.
REQ-016 btb_waddr  out  32  target written.
REQ-017 btb_wvalid  out  1  valid bit written.
REQ-018 entry_valid  out  BLOCKSIZE  shadow valid bit per entry.

Function
REQ-019 SHALL hold per-entry shadow state: valid bit, 32-bit tag, 2-bit saturating counter; plus a round-robin pointer rr_ptr (IW bits).
REQ-020 SHALL push {pc,target,taken} into the FIFO when upd_valid and upd_ready are both high.
REQ-021 upd_ready SHALL = !rst & !full & !flush_req & (state!=FLUSH).
REQ-022 FSM SHALL have states IDLE, WRITE and FLUSH.
REQ-023 IDLE: if flush_req -> FLUSH; else if queue non-empty -> pop head, compute decision, register btb_* outputs -> WRITE; else stay.
REQ-024 WRITE: btb_we=1 for exactly this cycle -> IDLE; throughput is one update per 2 cycles; latency from push edge to btb_we high is 2 cycles.
REQ-025 Tag hit, taken: counter saturating increment (max 11); write idx=hit, wpc=pc, waddr=target, wvalid=1.
REQ-026 Tag hit, not-taken: counter decrement; if the result is 00, clear valid and write wvalid=0; else rewrite the entry unchanged with wvalid=1.
REQ-027 Miss, taken: allocate the lowest-index invalid entry; if none, allocate rr_ptr and then rr_ptr=rr_ptr+1 mod BLOCKSIZE; counter=10; wvalid=1.
REQ-028 Miss, not-taken: drop, no write, go to IDLE instead of WRITE.
REQ-029 A hit requires a valid entry with tag==pc; at most one entry matches (uniqueness is guaranteed by allocation only on miss).
REQ-030 flush_req seen in WRITE SHALL let the write complete, then enter FLUSH.
REQ-031 FLUSH entry SHALL empty the queue, discarding pending updates.
REQ-032 FLUSH: BLOCKSIZE consecutive cycles of btb_we=1, btb_idx=0..BLOCKSIZE-1, wvalid=0, wpc=0, waddr=0; then clear all valid bits and counters, set rr_ptr=0, and return to IDLE.
REQ-033 flush_busy SHALL be high in every FLUSH cycle only.
REQ-034 flush_req during FLUSH SHALL be ignored and SHALL NOT restart the sequence.
REQ-035 btb_we SHALL be 0 in IDLE.
REQ-036 btb_wpc, btb_waddr, btb_idx and btb_wvalid SHALL hold their last values when btb_we=0.

Reset
REQ-037 While rst is high: state=IDLE, queue empty, all valid=0, counters=00, rr_ptr=0, btb_we=0, btb_idx=0, btb_wpc=0, btb_waddr=0, btb_wvalid=0, flush_busy=0, upd_ready=0.
REQ-038 rst asserted mid-WRITE or mid-FLUSH SHALL abort at the next edge with no further btb_we.

Verification
REQ-039 After reset, push pc=0x100, tgt=0x140, taken -> 2 cycles later btb_we=1, idx=0, wpc=0x100, waddr=0x140, wvalid=1; entry_valid=0001.
REQ-040 Push taken pcs 0x100/0x200/0x300/0x400/0x500 -> idx 0,1,2,3 and then idx 0 (rr_ptr); the fifth write has wpc=0x500.
REQ-041 Allocate 0x100, then push 0x100 not-taken twice -> first write wvalid=1, second write wvalid=0 (counter 10->01->00); entry_valid bit0 clears.
REQ-042 Queue full (QDEPTH pushes back-to-back) -> upd_ready=0 until the first pop; no update is lost or duplicated.
REQ-043 flush_req with 2 queued updates during WRITE -> write completes; then 4 cycles with flush_busy=1 and idx 0..3, wvalid=0; the queued updates are discarded; entry_valid=0000.
REQ-044 rst pulse in the second FLUSH cycle -> btb_we=0 the next cycle, all outputs at reset values.
